// File: rtl/sr_bank_driver.sv
// Sequencer that drives a bank of SR flip-flops to a target word, with read-back check and retry.
// Optional build macro SRDRV_FORCE_EN: forced writes (s=tgt, r=~tgt) instead of minimal excitation.
module sr_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic             c,
  input  logic             rs,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [2:0]       retry_q, retry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Both variants keep s and r disjoint per bit, so S=R=1 cannot be issued.
  function automatic logic [WIDTH-1:0] exc_s(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef SRDRV_FORCE_EN
    return t;
`else
    return t & ~q;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exc_r(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef SRDRV_FORCE_EN
    return ~t;
`else
    return q & ~t;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    s_d     = '0;
    r_d     = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target;
          retry_d = '0;
          err_d   = 1'b0;
          s_d     = exc_s(q_fb, target);
          r_d     = exc_r(q_fb, target);
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = WAIT;
      WAIT: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < MAX_R) begin
          retry_d = retry_q + 3'd1;
          s_d     = exc_s(q_fb, tgt_q);
          r_d     = exc_r(q_fb, tgt_q);
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rs) begin
    if (!rs) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      retry_q <= '0;
      s_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/sr_bank_driver.md
# sr_bank_driver

Sequencer that drives a bank of WIDTH SR flip-flops to a requested target word. It reads back the bank's q outputs and uses the SR excitation table to choose S/R per bit; it never issues S=R=1. It checks the result, retries on mismatch, and signals done or err. It sits upstream of the SR flip-flop bank and forms the write side of the S/R interface the flip-flops consume.

## Interface
- WIDTH, 8: number of SR flip-flops driven (1..32).
- MAX_RETRY, 2: extra DRIVE attempts allowed after the first mismatch (0..7).
- c  in  1  clock; all state changes on posedge c.
- rs  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- target  in  WIDTH  desired bank value; latched when start is accepted.
- q_fb  in  WIDTH  q outputs fed back from the SR flip-flop bank.
- s  out  WIDTH  set lines to the bank; registered.
- r  out  WIDTH  reset lines to the bank; registered.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse on successful match.
- err  out  1  sticky failure flag; cleared by the next accepted start.

## Operation
- States: IDLE, DRIVE, WAIT.
- Registers: tgt (WIDTH), retry counter (3 bits), s, r, done, err.
- IDLE with start=1:
  - Latch tgt=target; clear err and retry.
  - Load s/r from the excitation of (q_fb, target); go to DRIVE.
- Excitation per bit i (default build):
  - q=0, t=0 gives s=0, r=0.
  - q=0, t=1 gives s=1, r=0.
  - q=1, t=0 gives s=0, r=1.
  - q=1, t=1 gives s=0, r=0.
  - Don't-care entries resolve to 0.
- DRIVE: s/r held for exactly this cycle; next state WAIT, with s=r=0.
- WAIT: q_fb is compared with tgt at the closing edge.
  - Equal: go to IDLE with done=1 for one cycle.
  - Unequal and retry<MAX_RETRY: retry+1, reload s/r from the excitation of (q_fb, tgt), go to DRIVE.
  - Unequal and retry==MAX_RETRY: go to IDLE with err=1 (sticky) and no done.
- busy=1 in DRIVE and WAIT; busy=0 in IDLE.
- Invariant: (s & r)==0 in every cycle, in every build.

## Timing
- Reset (rs=0): state=IDLE; s=0, r=0, busy=0, done=0, err=0, tgt=0, retry=0. Outputs clear immediately, without waiting for c.
- Reset mid-operation: the request is abandoned, with no done and no err. s/r drop to 0 asynchronously.
- Let E0 be the edge that accepts start.
  - s/r are valid between E0 and E1, and the bank captures them at E1.
  - At E2, a match raises done (visible after E2), so done appears 2 cycles after accept.
- Each retry adds 2 cycles. Worst-case latency to done or err is 2*(MAX_RETRY+1) cycles.
- start while busy=1 is ignored and not queued.
- start held high continuously: a new request is accepted on the first IDLE cycle after done/err. done and the next accept may coincide on that edge.
- A target equal to current q_fb still runs DRIVE and WAIT with s=r=0, then pulses done after 2 cycles.
- target changes after accept have no effect; tgt is frozen until the next accept.

## Configuration
- SRDRV_FORCE_EN defined:
  - DRIVE uses forced writes: s=tgt, r=~tgt on all bits, regardless of q_fb.
  - This overrides any flip-flop holding a stale value; S=R=1 is still impossible.
- Undefined: minimal excitation as above. Bits already at target receive s=r=0.
- State machine, retry, done and err behaviour are identical in both builds.

## Test plan
- Reset with rs=0 mid-DRIVE (q_fb=8'h00, target=8'hA5) -> s, r, busy, done, err all 0 immediately; IDLE after release; no done.
- Model bank at 8'h0F, start with target=8'hF0 -> s=8'hF0, r=8'h0F in the DRIVE cycle; done exactly 2 cycles after accept. In a SRDRV_FORCE_EN build: s=8'hF0, r=8'h0F as well.
- Model bank at 8'h3C, target=8'h3C -> default build: s=r=8'h00, done 2 cycles after accept. Force build: s=8'h3C, r=8'hC3.
- Bank bit 0 stuck at 0, target=8'h01, MAX_RETRY=2 -> three DRIVE cycles each with s=8'h01; err=1 after 6 cycles; no done; err stays 1 until the next start.
- start pulsed during WAIT with a different target -> ignored; the original target completes; tgt is unchanged.
- Random q_fb and target for 1000 requests -> (s & r)==0 every cycle; bank equals target at every done.
